time_set_controller: RTL and testbench

- Sequences the user time-setting flow for the clock display.
- Consumes press and long-press pulses from the per-button debounce/press-detect blocks.
- Captures the running time, lets the user edit hour, minute and second fields, then issues a single-cycle load to the timekeeping counter.
- Also drives field-select and blink outputs for the display driver.

---
 rtl/time_set_controller.sv | 249 ++++++++++++++++++++++++
 tb/tb_time_set_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_controller.sv
`default_nettype none
// ============================================================================
//  Module      : time_set_controller
//  Description : Sequences the user time-setting flow of the clock display.
//                A long press on mode captures the running time and walks the
//                user through hour, minute and second editing; the final
//                mode press issues a single-cycle load to the timekeeper.
//                Also drives field-select and blink for the display driver.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock       in   1  system clock
//    reset       in   1  asynchronous, active-low reset
//    mode_press  in   1  one-cycle pulse, short press on mode
//    mode_long   in   1  one-cycle pulse, long press on mode
//    up_press    in   1  one-cycle pulse, short press on up
//    up_long     in   1  one-cycle pulse, long press on up
//    up_held     in   1  level, up button held down
//    down_press  in   1  one-cycle pulse, short press on down
//    cur_hour    in   5  running hour   (0-23)
//    cur_min     in   6  running minute (0-59)
//    cur_sec     in   6  running second (0-59)
//    set_hour    out  5  edited hour
//    set_min     out  6  edited minute
//    set_sec     out  6  edited second
//    load        out  1  one-cycle pulse, timekeeper loads set_*
//    editing     out  1  high in the hour/minute/second edit states
//    field       out  2  0 none, 1 hour, 2 minute, 3 second
//    blink       out  1  1 = show selected field, 0 = blank it
// ============================================================================
module time_set_controller #(
    parameter int REPEAT_W  = 18,
    parameter int BLINK_W   = 20,
    parameter int TIMEOUT_W = 25
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode_press,
    input  logic       mode_long,
    input  logic       up_press,
    input  logic       up_long,
    input  logic       up_held,
    input  logic       down_press,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       load,
    output logic       editing,
    output logic [1:0] field,
    output logic       blink
);

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_SET_HOUR = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_SET_SEC  = 3'd3,
        ST_COMMIT   = 3'd4
    } state_t;

    localparam logic [REPEAT_W-1:0]  C_REP_MAX   = '1;
    localparam logic [BLINK_W-1:0]   C_BLINK_MAX = '1;
    // Last count before the timeout counter reaches its all-ones value: the
    // idle cycle that would take it there is the one that aborts editing.
    localparam logic [TIMEOUT_W-1:0] C_TO_LAST   = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t                 state_q, state_d;
    logic [4:0]             set_hour_q, set_hour_d;
    logic [5:0]             set_min_q, set_min_d;
    logic [5:0]             set_sec_q, set_sec_d;
    logic                   load_q, load_d;
    logic                   rep_arm_q, rep_arm_d;
    logic [REPEAT_W-1:0]    rep_cnt_q, rep_cnt_d;
    logic [TIMEOUT_W-1:0]   to_cnt_q, to_cnt_d;
    logic [BLINK_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                   blink_q, blink_d;

    logic w_pulse;
    logic w_rep_tick;
    logic w_step_up;
    logic w_step_dn;
    logic w_stay_set;

    // Minute/second step with wrap; out-of-range values are folded back.
    function automatic logic [5:0] step60(input logic [5:0] v, input logic up);
        if (up) begin
            step60 = (v >= 6'd59) ? 6'd0 : v + 6'd1;
        end else begin
            step60 = (v == 6'd0 || v > 6'd59) ? 6'd59 : v - 6'd1;
        end
    endfunction

    function automatic logic [4:0] step24(input logic [4:0] v, input logic up);
        if (up) begin
            step24 = (v >= 5'd23) ? 5'd0 : v + 5'd1;
        end else begin
            step24 = (v == 5'd0 || v > 5'd23) ? 5'd23 : v - 5'd1;
        end
    endfunction

    assign w_pulse    = mode_press | mode_long | up_press | up_long | down_press;
    // Armed repeat is only ever set inside an edit state, so no state qualifier.
    assign w_rep_tick = rep_arm_q & up_held & ~up_long & (rep_cnt_q == C_REP_MAX);

    // Next-state and field editing
    always_comb begin
        state_d    = state_q;
        set_hour_d = set_hour_q;
        set_min_d  = set_min_q;
        set_sec_d  = set_sec_q;
        w_step_up  = 1'b0;
        w_step_dn  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mode_long) begin
                    state_d    = ST_SET_HOUR;
                    set_hour_d = cur_hour;
                    set_min_d  = cur_min;
                    set_sec_d  = cur_sec;
                end
            end
            ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: begin
                if (mode_long) begin
                    state_d = ST_RUN;
                end else if (mode_press) begin
                    case (state_q)
                        ST_SET_HOUR: state_d = ST_SET_MIN;
                        ST_SET_MIN:  state_d = ST_SET_SEC;
                        default:     state_d = ST_COMMIT;
                    endcase
                end else begin
                    // Opposing presses cancel; a repeat tick only counts when
                    // no manual press is present in the same cycle.
                    if (up_press && !down_press) begin
                        w_step_up = 1'b1;
                    end else if (down_press && !up_press) begin
                        w_step_dn = 1'b1;
                    end else if (!up_press && !down_press && w_rep_tick) begin
                        w_step_up = 1'b1;
                    end
                    if (!w_pulse && !up_held && (to_cnt_q == C_TO_LAST)) begin
                        state_d = ST_RUN;
                    end
                end

                if (w_step_up || w_step_dn) begin
                    case (state_q)
                        ST_SET_HOUR: set_hour_d = step24(set_hour_q, w_step_up);
                        ST_SET_MIN:  set_min_d  = step60(set_min_q, w_step_up);
                        default:     set_sec_d  = step60(set_sec_q, w_step_up);
                    endcase
                end
            end
            ST_COMMIT: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    // Repeat, timeout and blink counters
    always_comb begin
        w_stay_set  = ((state_d == ST_SET_HOUR) || (state_d == ST_SET_MIN) ||
                       (state_d == ST_SET_SEC)) && (state_d == state_q);
        rep_arm_d   = rep_arm_q;
        rep_cnt_d   = rep_cnt_q;
        to_cnt_d    = to_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        load_d      = (state_d == ST_COMMIT);

        if (!w_stay_set) begin
            rep_arm_d = 1'b0;
            rep_cnt_d = '0;
        end else if (up_long) begin
            rep_arm_d = 1'b1;
            rep_cnt_d = '0;
        end else if (!up_held) begin
            rep_arm_d = 1'b0;
            rep_cnt_d = '0;
        end else if (rep_arm_q) begin
            rep_cnt_d = rep_cnt_q + REPEAT_W'(1);
        end

        if (!w_stay_set || w_pulse || up_held) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TIMEOUT_W'(1);
        end

        // Any edit restarts the phase with the field visible.
        if (!w_stay_set || w_step_up || w_step_dn) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (blink_cnt_q == C_BLINK_MAX) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            set_hour_q  <= '0;
            set_min_q   <= '0;
            set_sec_q   <= '0;
            load_q      <= 1'b0;
            rep_arm_q   <= 1'b0;
            rep_cnt_q   <= '0;
            to_cnt_q    <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            set_hour_q  <= set_hour_d;
            set_min_q   <= set_min_d;
            set_sec_q   <= set_sec_d;
            load_q      <= load_d;
            rep_arm_q   <= rep_arm_d;
            rep_cnt_q   <= rep_cnt_d;
            to_cnt_q    <= to_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    always_comb begin
        editing = 1'b0;
        field   = 2'd0;
        case (state_q)
            ST_SET_HOUR: begin editing = 1'b1; field = 2'd1; end
            ST_SET_MIN:  begin editing = 1'b1; field = 2'd2; end
            ST_SET_SEC:  begin editing = 1'b1; field = 2'd3; end
            default:     ;
        endcase
    end

    assign set_hour = set_hour_q;
    assign set_min  = set_min_q;
    assign set_sec  = set_sec_q;
    assign load     = load_q;
    assign blink    = blink_q;

endmodule
`default_nettype wire

// File: tb/tb_time_set_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_set_controller
//  Description : Self-checking bench for time_set_controller with a
//                behavioural model of the setting flow, directed scenarios
//                and a randomized soak.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_time_set_controller;

    localparam int RW   = 4;
    localparam int BW   = 3;
    localparam int TW   = 6;
    localparam int RMAX = (1 << RW) - 1;
    localparam int BMAX = (1 << BW) - 1;
    localparam int TMAX = (1 << TW) - 1;

    logic       clock;
    logic       reset;
    logic       mode_press, mode_long, up_press, up_long, up_held, down_press;
    logic [4:0] cur_hour;
    logic [5:0] cur_min, cur_sec;
    logic [4:0] set_hour;
    logic [5:0] set_min, set_sec;
    logic       load, editing, blink;
    logic [1:0] field;

    time_set_controller #(
        .REPEAT_W  (RW),
        .BLINK_W   (BW),
        .TIMEOUT_W (TW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mode_press (mode_press),
        .mode_long  (mode_long),
        .up_press   (up_press),
        .up_long    (up_long),
        .up_held    (up_held),
        .down_press (down_press),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .set_hour   (set_hour),
        .set_min    (set_min),
        .set_sec    (set_sec),
        .load       (load),
        .editing    (editing),
        .field      (field),
        .blink      (blink)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    string phase = "init";

    // Model: mode 0 = running, 1..3 = editing hour/min/sec, 4 = commit.
    int m_mode;
    int m_val [1:3];
    int m_rep_on, m_rep_n, m_idle_n, m_ph_n;
    int m_load, m_blink;

    function automatic int modulus(input int f);
        return (f == 1) ? 24 : 60;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s: observed=%0d expected=%0d", phase, tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0;
        m_val[1] = 0; m_val[2] = 0; m_val[3] = 0;
        m_rep_on = 0; m_rep_n = 0; m_idle_n = 0; m_ph_n = 0;
        m_load = 0; m_blink = 1;
    endfunction

    function automatic void model_edge();
        int  nxt   = m_mode;
        int  step  = 0;
        bit  pulse = mode_press | mode_long | up_press | up_long | down_press;
        bit  rtick = (m_rep_on != 0) && up_held && !up_long && (m_rep_n == RMAX);
        bit  stay;
        if (m_mode == 0) begin
            if (mode_long) begin
                nxt = 1;
                m_val[1] = int'(cur_hour);
                m_val[2] = int'(cur_min);
                m_val[3] = int'(cur_sec);
            end
        end else if (m_mode == 4) begin
            nxt = 0;
        end else if (mode_long) begin
            nxt = 0;
        end else if (mode_press) begin
            nxt = m_mode + 1;
        end else begin
            if (up_press != down_press) step = up_press ? 1 : -1;
            else if (!up_press && rtick) step = 1;
            m_val[m_mode] = (m_val[m_mode] + step + modulus(m_mode)) % modulus(m_mode);
            if (!pulse && !up_held && (m_idle_n + 1 == TMAX)) nxt = 0;
        end

        stay = (nxt >= 1) && (nxt <= 3) && (nxt == m_mode);
        if (!stay) begin
            m_rep_on = 0; m_rep_n = 0; m_idle_n = 0;
        end else begin
            if (up_long) begin m_rep_on = 1; m_rep_n = 0; end
            else if (!up_held) begin m_rep_on = 0; m_rep_n = 0; end
            else if (m_rep_on != 0) m_rep_n = (m_rep_n + 1) % (RMAX + 1);
            m_idle_n = (pulse || up_held) ? 0 : m_idle_n + 1;
        end

        if (!stay || step != 0) begin
            m_blink = 1; m_ph_n = 0;
        end else if (m_ph_n == BMAX) begin
            m_blink = 1 - m_blink; m_ph_n = 0;
        end else begin
            m_ph_n++;
        end
        m_load = (nxt == 4) ? 1 : 0;
        m_mode = nxt;
    endfunction

    task automatic check_all();
        bit in_set = (m_mode >= 1) && (m_mode <= 3);
        check("editing",  32'(editing),  in_set ? 1 : 0);
        check("field",    32'(field),    in_set ? m_mode : 0);
        check("set_hour", 32'(set_hour), m_val[1]);
        check("set_min",  32'(set_min),  m_val[2]);
        check("set_sec",  32'(set_sec),  m_val[3]);
        check("load",     32'(load),     m_load);
        check("blink",    32'(blink),    m_blink);
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
        mode_press = 0; mode_long = 0; up_press = 0; up_long = 0; down_press = 0;
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
    endtask

    initial begin
        reset = 1'b0;
        mode_press = 0; mode_long = 0; up_press = 0; up_long = 0;
        up_held = 0; down_press = 0;
        set_cur(0, 0, 0);
        model_reset();

        // Reset state
        phase = "reset";
        #12;
        check("editing", 32'(editing), 0);
        check("field",   32'(field),   0);
        check("set_hour",32'(set_hour),0);
        check("load",    32'(load),    0);
        check("blink",   32'(blink),   1);
        reset = 1'b1;
        tick(); tick();

        // Entry and commit
        phase = "entry";
        set_cur(13, 45, 30);
        mode_long = 1; tick();
        check("cap_hour", 32'(set_hour), 13);
        check("cap_min",  32'(set_min),  45);
        check("cap_sec",  32'(set_sec),  30);
        check("field1",   32'(field),    1);
        mode_press = 1; tick();
        check("field2", 32'(field), 2);
        mode_press = 1; tick();
        check("field3", 32'(field), 3);
        mode_press = 1; tick();
        check("commit_load", 32'(load),    1);
        check("commit_edit", 32'(editing), 0);
        check("commit_hour", 32'(set_hour), 13);
        check("commit_sec",  32'(set_sec),  30);
        tick();
        check("after_load",  32'(load),  0);
        check("after_field", 32'(field), 0);

        // Wrap and abort via mode_long
        phase = "wrap";
        set_cur(23, 0, 12);
        mode_long = 1; tick();
        up_press = 1; tick();
        check("hour_wrap", 32'(set_hour), 0);
        mode_press = 1; tick();
        down_press = 1; tick();
        check("min_wrap", 32'(set_min), 59);
        mode_long = 1; tick();
        check("abort_edit", 32'(editing), 0);
        check("abort_load", 32'(load),    0);
        tick();
        check("hold_hour", 32'(set_hour), 0);
        check("hold_min",  32'(set_min),  59);

        // Auto-repeat
        phase = "repeat";
        set_cur(10, 20, 58);
        mode_long = 1; tick();
        mode_press = 1; tick();
        mode_press = 1; tick();
        check("rep_start", 32'(set_sec), 58);
        up_long = 1; up_held = 1; tick();
        check("rep_nostep", 32'(set_sec), 58);
        for (int k = 1; k <= 40; k++) begin
            tick();
            check("rep_sec", 32'(set_sec), (k < 16) ? 58 : (k < 32) ? 59 : 0);
        end
        up_held = 0;
        for (int k = 0; k < 20; k++) tick();
        check("rep_release", 32'(set_sec), 0);

        // Simultaneity
        phase = "simul";
        up_press = 1; down_press = 1; tick();
        check("updown", 32'(set_sec), 0);
        mode_long = 1; tick();
        set_cur(5, 10, 10);
        mode_long = 1; tick();
        mode_press = 1; up_press = 1; tick();
        check("mp_field", 32'(field),    2);
        check("mp_hour",  32'(set_hour), 5);

        // Inactivity timeout in SET_MIN
        phase = "timeout";
        for (int k = 0; k < 62; k++) tick();
        check("to_before", 32'(field), 2);
        tick();
        check("to_after_edit", 32'(editing), 0);
        check("to_after_load", 32'(load),    0);

        // Asynchronous reset mid-edit
        phase = "async_reset";
        set_cur(7, 8, 9);
        mode_long = 1; tick();
        mode_press = 1; tick();
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("ar_field", 32'(field),    0);
        check("ar_edit",  32'(editing),  0);
        check("ar_hour",  32'(set_hour), 0);
        check("ar_min",   32'(set_min),  0);
        check("ar_sec",   32'(set_sec),  0);
        check("ar_load",  32'(load),     0);
        check("ar_blink", 32'(blink),    1);
        #2 reset = 1'b1;
        tick();

        // Randomized soak against the model
        phase = "random";
        for (int n = 0; n < 3000; n++) begin
            set_cur($urandom_range(23, 0), $urandom_range(59, 0), $urandom_range(59, 0));
            mode_long  = ($urandom_range(39, 0) == 0);
            mode_press = ($urandom_range(11, 0) == 0);
            up_press   = ($urandom_range(5, 0) == 0);
            down_press = ($urandom_range(5, 0) == 0);
            up_long    = ($urandom_range(19, 0) == 0);
            if ($urandom_range(14, 0) == 0) up_held = ~up_held;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
